// File: rtl/idec_pkg.sv
// Shared types, field constants and the instruction-word decode helper for instr_decoder.
package idec_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    localparam logic [3:0] OP_REG    = 4'h0;
    localparam logic [3:0] OP_MEM    = 4'h4;
    localparam logic [3:0] OP_SHIFT  = 4'h8;
    localparam logic [3:0] OP_CMPI   = 4'hB;
    localparam logic [3:0] OP_BCOND  = 4'hC;
    localparam logic [3:0] OP_LUI    = 4'hF;

    localparam logic [3:0] EXT_LOAD      = 4'h0;
    localparam logic [3:0] EXT_STORE     = 4'h4;
    localparam logic [3:0] EXT_JCOND     = 4'hC;
    localparam logic [3:0] EXT_SHIFT_REG = 4'h4;

    localparam logic [7:0] ALU_NOP   = 8'h00;
    localparam logic [7:0] ALU_ADD   = 8'h05;
    localparam logic [7:0] ALU_CMP   = 8'h0B;
    localparam logic [7:0] ALU_LOAD  = 8'h40;
    localparam logic [7:0] ALU_STORE = 8'h44;
    localparam logic [7:0] ALU_LUI   = 8'hF0;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_HI = 4'h4;
    localparam logic [3:0] CC_LS = 4'h5;
    localparam logic [3:0] CC_GT = 4'h6;
    localparam logic [3:0] CC_LE = 4'h7;
    localparam logic [3:0] CC_UC = 4'hE;

    typedef struct packed {
        logic [7:0]  opcode;
        logic        imm_sel;
        logic [15:0] imm_value;
        logic        wr_en;
        logic        wb_sel;
    } dec_t;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic dec_t decode(input logic [15:0] w);
        dec_t       d;
        logic [3:0] op;
        logic [3:0] ext;
        logic [7:0] imm8;
        op   = w[15:12];
        ext  = w[7:4];
        imm8 = w[7:0];
        d    = '0;
        d.opcode = ALU_NOP;
        case (op)
            OP_REG: begin
                d.opcode = {4'h0, ext};
                d.wr_en  = ({4'h0, ext} != ALU_CMP);
            end
            4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, OP_CMPI, 4'hD: begin
                d.opcode    = {4'h0, op};
                d.imm_sel   = 1'b1;
                d.imm_value = sext8(imm8);
                d.wr_en     = (op != OP_CMPI);
            end
            OP_SHIFT: begin
                d.opcode    = {4'h8, ext};
                d.imm_sel   = (ext != EXT_SHIFT_REG);
                d.imm_value = sext8(imm8);
                d.wr_en     = 1'b1;
            end
            OP_LUI: begin
                d.opcode    = ALU_LUI;
                d.imm_sel   = 1'b1;
                d.imm_value = {8'h00, imm8};
                d.wr_en     = 1'b1;
            end
            OP_MEM: begin
                if (ext == EXT_LOAD) begin
                    d.opcode = ALU_LOAD;
                    d.wr_en  = 1'b1;
                    d.wb_sel = 1'b1;
                end else if (ext == EXT_STORE) begin
                    d.opcode = ALU_STORE;
                end
            end
            // branches, jumps and undefined ops leave the all-zero default
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluation from the ALU flag word; purely combinational.
module cond_eval
    import idec_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] psr,
    output logic       taken
);

    logic flag_n;
    logic flag_z;
    logic flag_l;
    logic unused_flags;

    assign flag_n       = psr[4];
    assign flag_z       = psr[3];
    assign flag_l       = psr[1];
    assign unused_flags = psr[2] ^ psr[0];

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken = flag_z;
            CC_NE:   taken = ~flag_z;
            CC_HI:   taken = flag_l;
            CC_LS:   taken = ~flag_l;
            CC_GT:   taken = flag_n;
            CC_LE:   taken = ~flag_n;
            CC_UC:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_decoder.sv
// Multi-cycle fetch/decode/execute sequencer owning the PC; ALU controls held DECODE..WB.
// Optional IDEC_STALL_EN adds a stall input that freezes the FSM and masks the strobes.
module instr_decoder
    import idec_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
`ifdef IDEC_STALL_EN
    input  logic        stall,
`endif
    input  logic [15:0] instr,
    input  logic [4:0]  psrIn,
    input  logic [15:0] regDataA,
    output logic [15:0] pc,
    output logic [7:0]  opcode,
    output logic [3:0]  raddrA,
    output logic [3:0]  raddrB,
    output logic        immSel,
    output logic [15:0] immValue,
    output logic [3:0]  waddr,
    output logic        wen,
    output logic        wbSel,
    output logic        memRead,
    output logic        memWrite
);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    dec_t        dec_q, dec_d;
    logic        wen_q, wen_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;

    logic run;
    logic taken;
    logic is_bcond;
    logic is_jcond;
    logic is_load;
    logic is_store;

`ifdef IDEC_STALL_EN
    assign run = ~stall;
`else
    assign run = 1'b1;
`endif

    assign is_bcond = (ir_q[15:12] == OP_BCOND);
    assign is_jcond = (ir_q[15:12] == OP_MEM) && (ir_q[7:4] == EXT_JCOND);
    assign is_load  = (ir_q[15:12] == OP_MEM) && (ir_q[7:4] == EXT_LOAD);
    assign is_store = (ir_q[15:12] == OP_MEM) && (ir_q[7:4] == EXT_STORE);

    cond_eval u_cond_eval (
        .cond  (ir_q[11:8]),
        .psr   (psrIn),
        .taken (taken)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        dec_d    = dec_q;
        wen_d    = 1'b0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // decode straight from memory so controls are valid from DECODE onward
                ir_d    = instr;
                dec_d   = decode(instr);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_bcond || is_jcond) begin
                    state_d = ST_FETCH;
                    if (!taken)
                        pc_d = pc_q + 16'd1;
                    else if (is_bcond)
                        pc_d = pc_q + sext8(ir_q[7:0]);
                    else
                        pc_d = regDataA;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_load || is_store) begin
                    state_d  = ST_MEM;
                    mem_rd_d = is_load;
                    mem_wr_d = is_store;
                end else begin
                    state_d = ST_WB;
                    wen_d   = dec_q.wr_en;
                end
            end
            ST_MEM: begin
                state_d = ST_WB;
                wen_d   = dec_q.wr_en;
            end
            ST_WB: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + 16'd1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            dec_q    <= '0;
            wen_q    <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
        end else if (run) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            dec_q    <= dec_d;
            wen_q    <= wen_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
        end
    end

    assign pc       = pc_q;
    assign opcode   = dec_q.opcode;
    assign immSel   = dec_q.imm_sel;
    assign immValue = dec_q.imm_value;
    assign wbSel    = dec_q.wb_sel;
    assign raddrA   = is_jcond ? ir_q[3:0] : ir_q[11:8];
    assign raddrB   = ir_q[3:0];
    assign waddr    = ir_q[11:8];
    // strobes stay registered through a stall but are masked until it lifts
    assign wen      = wen_q & run;
    assign memRead  = mem_rd_q & run;
    assign memWrite = mem_wr_q & run;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder: per-class sequencing, branch/jump resolution, reset and stall.
module tb_instr_decoder;

    logic        clock;
    logic        reset;
    logic [15:0] instr;
    logic [4:0]  psrIn;
    logic [15:0] regDataA;
    logic [15:0] pc;
    logic [7:0]  opcode;
    logic [3:0]  raddrA;
    logic [3:0]  raddrB;
    logic        immSel;
    logic [15:0] immValue;
    logic [3:0]  waddr;
    logic        wen;
    logic        wbSel;
    logic        memRead;
    logic        memWrite;
`ifdef IDEC_STALL_EN
    logic        stall;
`endif

    logic [15:0] imem [16];
    int errors = 0;
    int checks = 0;

    assign instr = imem[pc[3:0]];

    instr_decoder dut (
        .clock    (clock),
        .reset    (reset),
`ifdef IDEC_STALL_EN
        .stall    (stall),
`endif
        .instr    (instr),
        .psrIn    (psrIn),
        .regDataA (regDataA),
        .pc       (pc),
        .opcode   (opcode),
        .raddrA   (raddrA),
        .raddrB   (raddrB),
        .immSel   (immSel),
        .immValue (immValue),
        .waddr    (waddr),
        .wen      (wen),
        .wbSel    (wbSel),
        .memRead  (memRead),
        .memWrite (memWrite)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
    endtask

    // one 4-cycle ALU-class instruction at address 0
    task automatic run_alu(input string tag, input logic [15:0] w, input logic [7:0] op,
                           input logic sel, input logic [15:0] imm, input logic we);
        clear_imem();
        imem[0] = w;
        do_reset();
        tick(2);
        chk({tag, ".op"}, {8'h00, opcode}, {8'h00, op});
        chk({tag, ".sel"}, {15'h0, immSel}, {15'h0, sel});
        chk({tag, ".imm"}, immValue, imm);
        tick(1);
        chk({tag, ".wen"}, {15'h0, wen}, {15'h0, we});
        chk({tag, ".waddr"}, {12'h0, waddr}, {12'h0, w[11:8]});
        chk({tag, ".pc_wb"}, pc, 16'h0000);
        tick(1);
        chk({tag, ".pc_next"}, pc, 16'h0001);
        chk({tag, ".wen_off"}, {15'h0, wen}, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        psrIn    = 5'b0;
        regDataA = 16'h0;
`ifdef IDEC_STALL_EN
        stall    = 1'b0;
`endif
        clear_imem();
        #3;
        chk("rst.pc", pc, 16'h0000);
        chk("rst.op", {8'h00, opcode}, 16'h0000);
        chk("rst.imm", immValue, 16'h0000);
        chk("rst.addr", {4'h0, raddrA, raddrB, waddr}, 16'h0000);
        chk("rst.strobes", {11'h0, immSel, wen, wbSel, memRead, memWrite}, 16'h0000);

        run_alu("addi",  16'h5105, 8'h05, 1'b1, 16'h0005, 1'b1);
        run_alu("addin", 16'h51FE, 8'h05, 1'b1, 16'hFFFE, 1'b1);
        run_alu("cmp",   16'h02B3, 8'h0B, 1'b0, 16'h0000, 1'b0);
        run_alu("cmpi",  16'hB27F, 8'h0B, 1'b1, 16'h007F, 1'b0);
        run_alu("lui",   16'hF3AB, 8'hF0, 1'b1, 16'h00AB, 1'b1);
        run_alu("shreg", 16'h8243, 8'h84, 1'b0, 16'h0043, 1'b1);
        run_alu("shimm", 16'h8201, 8'h80, 1'b1, 16'h0001, 1'b1);
        run_alu("undef", 16'hA123, 8'h00, 1'b0, 16'h0000, 1'b0);

        // CMP then BEQ +4, Z set and clear
        for (int z = 1; z >= 0; z--) begin
            clear_imem();
            imem[0] = 16'h02B3;
            imem[1] = 16'hC004;
            psrIn   = (z == 1) ? 5'b01000 : 5'b00000;
            do_reset();
            tick(4);
            chk("beq.pc_cmp", pc, 16'h0001);
            tick(1);
            chk("beq.pc_dec", pc, 16'h0001);
            chk("beq.wen", {15'h0, wen}, 16'h0000);
            tick(1);
            chk("beq.pc", pc, (z == 1) ? 16'h0005 : 16'h0002);
        end

        // BNE with Z set is not taken; GT with N set is taken
        clear_imem();
        imem[0] = 16'hC103;
        psrIn   = 5'b01000;
        do_reset();
        tick(2);
        chk("bne.pc", pc, 16'h0001);
        clear_imem();
        imem[0] = 16'hC606;
        psrIn   = 5'b10000;
        do_reset();
        tick(2);
        chk("bgt.pc", pc, 16'h0006);

        // BUC -1 from address 0 wraps
        clear_imem();
        imem[0] = 16'hCEFF;
        psrIn   = 5'b0;
        do_reset();
        tick(2);
        chk("buc.pc", pc, 16'hFFFF);

        // JUC R7
        clear_imem();
        imem[0]  = 16'h4EC7;
        regDataA = 16'h1234;
        do_reset();
        tick(1);
        chk("juc.raddrA", {12'h0, raddrA}, 16'h0007);
        tick(1);
        chk("juc.pc", pc, 16'h1234);

        // LOAD R4,[R5]
        clear_imem();
        imem[0] = 16'h4405;
        do_reset();
        tick(1);
        chk("ld.op", {8'h00, opcode}, 16'h0040);
        chk("ld.rd_dec", {15'h0, memRead}, 16'h0000);
        tick(1);
        chk("ld.rd_exec", {15'h0, memRead}, 16'h0000);
        tick(1);
        chk("ld.rd_mem", {14'h0, memRead, memWrite}, 16'h0002);
        tick(1);
        chk("ld.wb", {13'h0, memRead, wen, wbSel}, 16'h0003);
        chk("ld.waddr", {12'h0, waddr}, 16'h0004);
        chk("ld.pc_wb", pc, 16'h0000);
        tick(1);
        chk("ld.pc", pc, 16'h0001);

        // STORE
        clear_imem();
        imem[0] = 16'h4345;
        do_reset();
        tick(3);
        chk("st.op", {8'h00, opcode}, 16'h0044);
        chk("st.mem", {14'h0, memRead, memWrite}, 16'h0001);
        tick(1);
        chk("st.wb", {14'h0, memWrite, wen}, 16'h0000);
        tick(1);
        chk("st.pc", pc, 16'h0001);

        // reset dropped in WB of ADD at address 1
        clear_imem();
        imem[0] = 16'h5105;
        imem[1] = 16'h0251;
        do_reset();
        tick(7);
        chk("arst.wen_before", {15'h0, wen}, 16'h0001);
        chk("arst.pc_before", pc, 16'h0001);
        reset = 1'b0;
        #1;
        chk("arst.wen", {15'h0, wen}, 16'h0000);
        chk("arst.pc", pc, 16'h0000);
        @(negedge clock);
        reset = 1'b1;
        tick(1);
        chk("arst.refetch", {7'h0, immSel, opcode}, 16'h0105);

`ifdef IDEC_STALL_EN
        clear_imem();
        imem[0] = 16'h5105;
        do_reset();
        tick(2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("stall.pc", pc, 16'h0000);
            chk("stall.op", {8'h00, opcode}, 16'h0005);
            chk("stall.wen", {15'h0, wen}, 16'h0000);
        end
        stall = 1'b0;
        tick(1);
        chk("stall.wb", {15'h0, wen}, 16'h0001);
        stall = 1'b1;
        #1;
        chk("stall.wen_mask", {15'h0, wen}, 16'h0000);
        stall = 1'b0;
        #1;
        chk("stall.wen_back", {15'h0, wen}, 16'h0001);
        tick(1);
        chk("stall.pc_done", pc, 16'h0001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_decoder.md
# instr_decoder

Multi-cycle fetch/decode controller for the 16-bit datapath. It latches each instruction word from instruction memory and translates it into the 8-bit ALU opcode, register-file read/write addresses and immediate operand. It sequences the registered ALU through execute and writeback, and resolves branches and jumps from the ALU's 5-bit PSR flags. It sits directly upstream of the ALU and owns the program counter.

## Interface
- No parameters. Widths are fixed: 16-bit data, 4-bit register address, 8-bit ALU opcode.
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; low forces every register to its reset value immediately.
- `instr`  in  16  instruction memory read data for address `pc`.
- `psrIn`  in  5  ALU flags: [4]=N, [3]=Z, [2]=F, [1]=L, [0]=C.
- `regDataA`  in  16  register file read port A data, used as the jump target.
- `pc`  out  16  instruction address; word addressed.
- `opcode`  out  8  ALU opcode.
- `raddrA`  out  4  register file read address A (Rdest).
- `raddrB`  out  4  register file read address B (Rsrc).
- `immSel`  out  1  selects the immediate as ALU operand B.
- `immValue`  out  16  immediate for operand B.
- `waddr`  out  4  register file write address.
- `wen`  out  1  register file write enable.
- `wbSel`  out  1  writeback source: 0 = ALU result, 1 = memory read data.
- `memRead`  out  1  data memory read strobe.
- `memWrite`  out  1  data memory write strobe.

## Operation
- Instruction fields: [15:12] op, [11:8] Rdest/cond, [7:4] ext, [3:0] Rsrc; [7:0] imm8 for immediate forms.
- State machine states:
  - FETCH: IR <= `instr`; go to DECODE.
  - DECODE: classify the instruction.
    - Bcond (op 1100) and Jcond (op 0100, ext 1100) go to FETCH and update `pc` here.
    - All other instructions go to EXEC.
  - EXEC: drives `opcode`/`immSel`/`immValue`; the ALU captures on this edge.
    - LOAD/STORE go to MEM; all others go to WB.
  - MEM: `memRead` (LOAD) or `memWrite` (STORE) high for exactly one cycle; go to WB.
  - WB: `wen` high for one cycle where applicable; `pc` <= `pc`+1; go to FETCH.
- Opcode mapping:
  - Register form (op 0000): {0000, ext}.
  - Immediate ALU forms (op 0001..0111 except 0100, op 1001, op 1011, op 1101): opcode = {0000, op}, `immSel`=1.
  - `immValue` = sign-extended imm8.
  - Shifts (op 1000): {1000, ext}; `immSel`=1 unless ext=0100.
  - LUI (op 1111): opcode 0xF0, `immValue`={8'b0, imm8}.
  - LOAD: opcode 0x40. STORE: opcode 0x44.
- `wen`:
  - 0 for CMP (reg 0x0B, imm op 1011), STORE, branches, jumps, and undefined ops.
  - 1 otherwise; `waddr`=Rdest.
  - `wbSel`=1 only for LOAD.
- Condition evaluation (cond field [11:8]; Z,L,N taken from `psrIn`):
  - EQ 0000: Z.
  - NE 0001: !Z.
  - HI 0100: L.
  - LS 0101: !L.
  - GT 0110: N.
  - LE 0111: !N.
  - UC 1110: always.
  - Any other code: never taken.
- Bcond taken: `pc` <= `pc` + sext(imm8), 16-bit wrap-around. Not taken: `pc`+1.
- Jcond taken: `pc` <= `regDataA`, with `raddrA`=Rsrc during DECODE. Not taken: `pc`+1.
- Undefined op: opcode 0x00 (ALU yields 0), `wen`=0; proceeds FETCH→DECODE→EXEC→WB→FETCH.

## Timing
- Reset values: `pc`=0x0000, state FETCH, IR=0, `opcode`=0x00, all addresses 0, `immValue`=0, `immSel`/`wen`/`wbSel`/`memRead`/`memWrite`=0.
- Latency per instruction class:
  - ALU op: 4 cycles.
  - LOAD/STORE: 5 cycles.
  - Branch/jump: 2 cycles.
- `instr` must be valid in the FETCH cycle; asynchronous-read memory, no wait states.
- `opcode`, `immValue` and addresses are held stable from DECODE through WB, so ALU inputs never change mid-instruction.
- The ALU result registered at the end of EXEC is valid during MEM/WB, and `wen` is asserted in WB.
- `psrIn` is sampled in DECODE, so a CMP immediately followed by a branch sees the updated flags.
- Reset asserted mid-instruction: outputs go to reset values asynchronously; a pending `wen`/`memWrite` is dropped. Execution restarts at FETCH, `pc`=0, on the first edge after reset is released.

## Configuration
- `IDEC_STALL_EN` defined: adds input `stall` (1 bit).
  - While `stall`=1 the state, `pc`, IR and all outputs hold.
  - `wen`/`memRead`/`memWrite` are forced to 0 during stall and reassert when it is released.
- Not defined: the `stall` port is absent and the FSM never waits.

## Structure
- Shared package `idec_pkg`:
  - State enum (FETCH, DECODE, EXEC, MEM, WB).
  - Op/ext constants.
  - ALU opcode constants (0x05, 0x0B, 0x40, 0x44, 0xF0, ...).
  - Condition-code constants.
- One sub-module, `cond_eval`: combinational; takes cond[3:0] and psr[4:0] and returns taken.

## Test plan
- Reset then ADDI R1,#5 (0x5105): `pc` 0→1 after 4 cycles; in EXEC `opcode`=0x05, `immSel`=1, `immValue`=0x0005; in WB `wen`=1, `waddr`=1.
- CMP R2,R3 (0x02B3) then BEQ +4 (0xC004) with `psrIn`[3]=1: `wen` stays 0 for the CMP; `pc` becomes 1+4=5 two cycles after the BEQ fetch. With Z=0, `pc`=2.
- BUC −1 (0xCEFF) at `pc`=0: `pc` wraps to 0xFFFF.
- LOAD R4,[R5] (0x4405): `opcode`=0x40, `memRead` high in the MEM cycle only, WB with `wbSel`=1, `waddr`=4; total 5 cycles.
- Drop `reset` during WB of an ADD: `wen` falls immediately, `pc`=0. After release, the first FETCH is at address 0.
- With `IDEC_STALL_EN` defined, assert `stall` for 3 cycles in EXEC: `pc` and `opcode` are unchanged throughout, and the instruction finishes 3 cycles late.
